sprite_attr_table: RTL and testbench
====================================

# sprite_attr_table

Parametrised, double-buffered sprite attribute table for the GPU. Replaces the hard-coded scene generator: a CPU-side write port fills a shadow copy of N sprite records (id, x, y, color), and a commit request publishes the whole shadow copy to the active copy atomically at the next frame end. The active copy drives the flattened sprite buses consumed by the sprite renderer. With motion compiled in, per-sprite velocities also move sprites autonomously once per frame.

## Interface
- N_SPRITES, 64, number of sprite records; level k occupies slice [k*W +: W] of each bus.
- ID_W, 6, sprite id width.
- POS_W, 10, x/y width.
- COLOR_W, 16, color width (RGB565).
- H_FRAME_END, 639, h_pos value that marks frame end.
- V_FRAME_END, 479, v_pos value that marks frame end.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- h_pos  in  10  current VGA column.
- v_pos  in  10  current VGA line.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_index  in  $clog2(N_SPRITES)  target record.
- wr_field  in  3  0=id, 1=x, 2=y, 3=color, 4=vx, 5=vy, 6/7 reserved (ignored).
- wr_data  in  16  value, LSB-aligned, truncated to field width.
- commit  in  1  single-cycle request to publish shadow at next frame end.
- commit_pending  out  1  commit latched, swap not yet done.
- frame_tick  out  1  one-cycle pulse, one cycle after frame-end detection.
- sprite_id_out  out  N_SPRITES*ID_W  active ids.
- sprite_x_out  out  N_SPRITES*POS_W  active x.
- sprite_y_out  out  N_SPRITES*POS_W  active y.
- sprite_color_out  out  N_SPRITES*COLOR_W  active colors.

## Operation
- Frame end event: h_pos==H_FRAME_END && v_pos==V_FRAME_END in this cycle and not in the previous cycle (rising-edge detect on registered compare).
- Writes always target the shadow copy; active copy is never written directly by the port.
- FSM states: IDLE, PENDING, SWAP.
  - IDLE: commit -> PENDING, commit_pending=1.
  - PENDING: frame end event -> SWAP; further commit pulses are absorbed (no queueing).
  - SWAP: one cycle; wr_ready=0; at its end active <= shadow (all fields), commit_pending=0, -> IDLE.
- Write accepted in the frame-end cycle itself is included in the swap.
- commit arriving in the SWAP cycle is ignored; the caller re-issues it after commit_pending falls.
- Shadow persists after swap (incremental edits are allowed).
- Reserved wr_field values: handshake completes, no state change.
- Reset mid-operation (any state): FSM -> IDLE, pending commit dropped, both copies cleared.

## Timing
- Reset values: all sprite buses 0, shadow 0, velocities 0, commit_pending 0, frame_tick 0, wr_ready 0 while rst is high, 1 the cycle after.
- Write latency: shadow updated on the acceptance edge; visible on outputs only after a swap.
- Swap latency: frame end detected at cycle T; SWAP at T+1; new active values on outputs at T+2; frame_tick high in cycle T+1.
- commit_pending rises the cycle after commit is sampled and falls with the active update.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SPRITE_MOTION_EN defined: each record holds signed 4-bit vx, vy (fields 4/5, wr_data[3:0]). On every frame end not followed by a swap, active x += sign-extended vx, y += vy, modulo 2^POS_W (wrap-around, no clamping). In a swap frame the swap wins and no motion is applied. Velocities are copied shadow->active on swap.
- Not defined: no velocity storage; fields 4/5 behave as reserved; active positions change only on swap.

## Structure
- Shared package gpu_pkg: field encodings (FIELD_ID..FIELD_VY), default widths, RGB565 constants.
- Sub-module sprite_motion_unit (one instance per record, generate loop), present only under SPRITE_MOTION_EN: current x/y, vx/vy, and an enable in; next x/y out.

## Test plan
- Reset: assert rst 3 cycles -> all buses 0, commit_pending 0, wr_ready 0 during reset, 1 after.
- Write index 63 id=0x05, x=0x96, y=0xA2, color=0xFFFF, commit -> outputs unchanged until frame end; at T+2 slice 63 reads 05/096/0A2/FFFF, commit_pending falls.
- Write without commit across two frame ends -> active copy unchanged, frame_tick pulses twice.
- Write accepted in the exact frame-end cycle while PENDING -> value present after swap; write attempted in SWAP sees wr_ready=0 and completes next cycle.
- Reset asserted while PENDING -> commit_pending 0, next frame end performs no swap.
- SPRITE_MOTION_EN: x=0x3FE, vx=+3, commit, then one more frame end -> x=0x3FE after swap, 0x001 after next frame (wrap); vx=-1 (0xF) from x=0 -> 0x3FF.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the GPU sprite path.
//   - default geometry/width values used by sprite_attr_table
//   - write-port field encodings (FIELD_ID .. FIELD_VY)
//   - RGB565 colour constants
//   - commit FSM state type (exposed on the table's debug port)
package gpu_pkg;

  localparam int DEF_N_SPRITES   = 64;
  localparam int DEF_ID_W        = 6;
  localparam int DEF_POS_W       = 10;
  localparam int DEF_COLOR_W     = 16;
  localparam int DEF_H_FRAME_END = 639;
  localparam int DEF_V_FRAME_END = 479;

  // Velocity components are signed 4-bit values.
  localparam int VEL_W = 4;

  localparam logic [2:0] FIELD_ID    = 3'd0;
  localparam logic [2:0] FIELD_X     = 3'd1;
  localparam logic [2:0] FIELD_Y     = 3'd2;
  localparam logic [2:0] FIELD_COLOR = 3'd3;
  localparam logic [2:0] FIELD_VX    = 3'd4;
  localparam logic [2:0] FIELD_VY    = 3'd5;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } commit_state_e;

endpackage

// File: rtl/sprite_motion_unit.sv
// sprite_motion_unit: next-position calculator for one sprite record.
// Only instantiated when SPRITE_MOTION_EN is defined.
//   x_i, y_i   current active position
//   vx_i, vy_i signed 4-bit velocity
//   en_i       apply velocity this cycle
//   x_o, y_o   next position (wraps modulo 2^POS_W; equals input when en_i=0)
module sprite_motion_unit
  import gpu_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
) (
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  input  logic [VEL_W-1:0] vx_i,
  input  logic [VEL_W-1:0] vy_i,
  input  logic             en_i,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o
);

  logic [POS_W-1:0] vx_ext;
  logic [POS_W-1:0] vy_ext;

  // Sign-extend so that a plain POS_W-bit add gives the wrap-around result.
  assign vx_ext = {{(POS_W-VEL_W){vx_i[VEL_W-1]}}, vx_i};
  assign vy_ext = {{(POS_W-VEL_W){vy_i[VEL_W-1]}}, vy_i};

  assign x_o = en_i ? (x_i + vx_ext) : x_i;
  assign y_o = en_i ? (y_i + vy_ext) : y_i;

endmodule

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: double-buffered sprite attribute table.
// The write port fills a shadow copy; a commit publishes the whole shadow
// copy to the active copy at the next frame end. The active copy drives the
// flattened sprite buses (record k at slice [k*W +: W]).
// Optional feature macro: SPRITE_MOTION_EN (per-sprite velocities, applied
// once per frame end that is not a swap frame).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   h_pos, v_pos        raster position, frame end = (H_FRAME_END, V_FRAME_END)
//   wr_valid/wr_ready   write handshake; wr_index/wr_field/wr_data payload
//   commit              request publish at next frame end
//   commit_pending      commit latched, swap not yet done
//   frame_tick          one-cycle pulse, one cycle after frame-end detection
//   sprite_*_out        active copy, flattened
//   fsm_state_o         debug view of the commit FSM state
// Handshake: a write transfers on any rising clk edge where wr_valid and
// wr_ready are both high; wr_ready is registered and low during reset and
// during the swap cycle; the payload must be stable while wr_valid is high.
module sprite_attr_table
  import gpu_pkg::*;
#(
  parameter int N_SPRITES   = DEF_N_SPRITES,
  parameter int ID_W        = DEF_ID_W,
  parameter int POS_W       = DEF_POS_W,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int H_FRAME_END = DEF_H_FRAME_END,
  parameter int V_FRAME_END = DEF_V_FRAME_END
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [9:0]                     h_pos,
  input  logic [9:0]                     v_pos,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [$clog2(N_SPRITES)-1:0]   wr_index,
  input  logic [2:0]                     wr_field,
  input  logic [15:0]                    wr_data,
  input  logic                           commit,
  output logic                           commit_pending,
  output logic                           frame_tick,
  output logic [N_SPRITES*ID_W-1:0]      sprite_id_out,
  output logic [N_SPRITES*POS_W-1:0]     sprite_x_out,
  output logic [N_SPRITES*POS_W-1:0]     sprite_y_out,
  output logic [N_SPRITES*COLOR_W-1:0]   sprite_color_out,
  output logic [1:0]                     fsm_state_o
);

  localparam logic [9:0] H_END = H_FRAME_END[9:0];
  localparam logic [9:0] V_END = V_FRAME_END[9:0];

  commit_state_e state_q, state_d;
  logic fe_cmp_q, fe_cmp_prev_q, fe_evt;
  logic frame_tick_q, wr_ready_q, commit_pending_q;
  logic wr_accept;

  logic [ID_W-1:0]    sh_id_q  [N_SPRITES];
  logic [POS_W-1:0]   sh_x_q   [N_SPRITES];
  logic [POS_W-1:0]   sh_y_q   [N_SPRITES];
  logic [COLOR_W-1:0] sh_col_q [N_SPRITES];
  logic [ID_W-1:0]    ac_id_q  [N_SPRITES];
  logic [POS_W-1:0]   ac_x_q   [N_SPRITES];
  logic [POS_W-1:0]   ac_y_q   [N_SPRITES];
  logic [COLOR_W-1:0] ac_col_q [N_SPRITES];
`ifdef SPRITE_MOTION_EN
  logic [VEL_W-1:0]   sh_vx_q  [N_SPRITES];
  logic [VEL_W-1:0]   sh_vy_q  [N_SPRITES];
  logic [VEL_W-1:0]   ac_vx_q  [N_SPRITES];
  logic [VEL_W-1:0]   ac_vy_q  [N_SPRITES];
  logic [POS_W-1:0]   mot_x    [N_SPRITES];
  logic [POS_W-1:0]   mot_y    [N_SPRITES];
  logic               motion_en;
`endif

  // Rising edge of the registered compare, so a raster parked on the
  // frame-end position still produces a single event.
  assign fe_evt    = fe_cmp_q && !fe_cmp_prev_q;
  assign wr_accept = wr_valid && wr_ready_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (commit) state_d = ST_PENDING;
      ST_PENDING: if (fe_evt) state_d = ST_SWAP;   // extra commits absorbed
      ST_SWAP:    state_d = ST_IDLE;               // commit here is dropped
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      fe_cmp_q         <= 1'b0;
      fe_cmp_prev_q    <= 1'b0;
      frame_tick_q     <= 1'b0;
      wr_ready_q       <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fe_cmp_q         <= (h_pos == H_END) && (v_pos == V_END);
      fe_cmp_prev_q    <= fe_cmp_q;
      frame_tick_q     <= fe_evt;
      wr_ready_q       <= (state_d != ST_SWAP);
      commit_pending_q <= (state_d != ST_IDLE);
    end
  end

  // Shadow copy: only the write port changes it, and a swap leaves it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SPRITES; k++) begin
        sh_id_q[k]  <= '0;
        sh_x_q[k]   <= '0;
        sh_y_q[k]   <= '0;
        sh_col_q[k] <= '0;
`ifdef SPRITE_MOTION_EN
        sh_vx_q[k]  <= '0;
        sh_vy_q[k]  <= '0;
`endif
      end
    end else if (wr_accept) begin
      case (wr_field)
        FIELD_ID:    sh_id_q[wr_index]  <= wr_data[ID_W-1:0];
        FIELD_X:     sh_x_q[wr_index]   <= wr_data[POS_W-1:0];
        FIELD_Y:     sh_y_q[wr_index]   <= wr_data[POS_W-1:0];
        FIELD_COLOR: sh_col_q[wr_index] <= wr_data[COLOR_W-1:0];
`ifdef SPRITE_MOTION_EN
        FIELD_VX:    sh_vx_q[wr_index]  <= wr_data[VEL_W-1:0];
        FIELD_VY:    sh_vy_q[wr_index]  <= wr_data[VEL_W-1:0];
`endif
        default: ;  // reserved fields: handshake only
      endcase
    end
  end

`ifdef SPRITE_MOTION_EN
  // Motion is applied in the frame_tick cycle unless that cycle is the swap.
  assign motion_en = frame_tick_q && (state_q != ST_SWAP);

  for (genvar k = 0; k < N_SPRITES; k++) begin : g_motion
    sprite_motion_unit #(.POS_W(POS_W)) u_motion (
      .x_i  (ac_x_q[k]),
      .y_i  (ac_y_q[k]),
      .vx_i (ac_vx_q[k]),
      .vy_i (ac_vy_q[k]),
      .en_i (motion_en),
      .x_o  (mot_x[k]),
      .y_o  (mot_y[k])
    );
  end
`endif

  // Active copy: loaded whole at the end of the SWAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SPRITES; k++) begin
        ac_id_q[k]  <= '0;
        ac_x_q[k]   <= '0;
        ac_y_q[k]   <= '0;
        ac_col_q[k] <= '0;
`ifdef SPRITE_MOTION_EN
        ac_vx_q[k]  <= '0;
        ac_vy_q[k]  <= '0;
`endif
      end
    end else if (state_q == ST_SWAP) begin
      for (int k = 0; k < N_SPRITES; k++) begin
        ac_id_q[k]  <= sh_id_q[k];
        ac_x_q[k]   <= sh_x_q[k];
        ac_y_q[k]   <= sh_y_q[k];
        ac_col_q[k] <= sh_col_q[k];
`ifdef SPRITE_MOTION_EN
        ac_vx_q[k]  <= sh_vx_q[k];
        ac_vy_q[k]  <= sh_vy_q[k];
`endif
      end
`ifdef SPRITE_MOTION_EN
    end else begin
      for (int k = 0; k < N_SPRITES; k++) begin
        ac_x_q[k] <= mot_x[k];
        ac_y_q[k] <= mot_y[k];
      end
`endif
    end
  end

  for (genvar k = 0; k < N_SPRITES; k++) begin : g_out
    assign sprite_id_out[k*ID_W +: ID_W]          = ac_id_q[k];
    assign sprite_x_out[k*POS_W +: POS_W]         = ac_x_q[k];
    assign sprite_y_out[k*POS_W +: POS_W]         = ac_y_q[k];
    assign sprite_color_out[k*COLOR_W +: COLOR_W] = ac_col_q[k];
  end

  assign wr_ready       = wr_ready_q;
  assign commit_pending = commit_pending_q;
  assign frame_tick     = frame_tick_q;
  assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_sprite_attr_table.sv
// Testbench for sprite_attr_table. A behavioural model tracks the shadow and
// active copies as plain arrays; frame ends are driven as a single-cycle
// raster position at (639, 479). Build with SPRITE_MOTION_EN to exercise motion.
module tb_sprite_attr_table;

  localparam int N  = 64;
  localparam int IW = 6;
  localparam int PW = 10;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [9:0]      h_pos, v_pos;
  logic            wr_valid, wr_ready;
  logic [5:0]      wr_index;
  logic [2:0]      wr_field;
  logic [15:0]     wr_data;
  logic            commit, commit_pending, frame_tick;
  logic [N*IW-1:0] sprite_id_out;
  logic [N*PW-1:0] sprite_x_out, sprite_y_out;
  logic [N*CW-1:0] sprite_color_out;
  logic [1:0]      fsm_state;

  sprite_attr_table dut (
    .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
    .wr_field(wr_field), .wr_data(wr_data), .commit(commit),
    .commit_pending(commit_pending), .frame_tick(frame_tick),
    .sprite_id_out(sprite_id_out), .sprite_x_out(sprite_x_out),
    .sprite_y_out(sprite_y_out), .sprite_color_out(sprite_color_out),
    .fsm_state_o(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [IW-1:0] m_sh_id[N], m_ac_id[N];
  logic [PW-1:0] m_sh_x[N], m_ac_x[N], m_sh_y[N], m_ac_y[N];
  logic [CW-1:0] m_sh_c[N], m_ac_c[N];
  logic [3:0]    m_sh_vx[N], m_ac_vx[N], m_sh_vy[N], m_ac_vy[N];
  bit            m_pending;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_sh_id[k] = '0; m_ac_id[k] = '0; m_sh_x[k] = '0; m_ac_x[k] = '0;
      m_sh_y[k] = '0; m_ac_y[k] = '0; m_sh_c[k] = '0; m_ac_c[k] = '0;
      m_sh_vx[k] = '0; m_ac_vx[k] = '0; m_sh_vy[k] = '0; m_ac_vy[k] = '0;
    end
    m_pending = 0;
  endfunction

  function automatic void model_write(input int idx, input int field, input logic [15:0] d);
    case (field)
      0: m_sh_id[idx] = d[IW-1:0];
      1: m_sh_x[idx]  = d[PW-1:0];
      2: m_sh_y[idx]  = d[PW-1:0];
      3: m_sh_c[idx]  = d;
`ifdef SPRITE_MOTION_EN
      4: m_sh_vx[idx] = d[3:0];
      5: m_sh_vy[idx] = d[3:0];
`endif
      default: ;
    endcase
  endfunction

  // Position plus signed velocity, wrapped into 0..1023.
  function automatic logic [PW-1:0] moved(input logic [PW-1:0] p, input logic [3:0] v);
    int sv;
    int r;
    sv = (v >= 4'd8) ? int'(v) - 16 : int'(v);
    r  = (int'(p) + sv + 1024) % 1024;
    return r[PW-1:0];
  endfunction

  function automatic void model_frame_end();
    if (m_pending) begin
      m_ac_id = m_sh_id; m_ac_x = m_sh_x; m_ac_y = m_sh_y; m_ac_c = m_sh_c;
      m_ac_vx = m_sh_vx; m_ac_vy = m_sh_vy;
      m_pending = 0;
    end else begin
`ifdef SPRITE_MOTION_EN
      for (int k = 0; k < N; k++) begin
        m_ac_x[k] = moved(m_ac_x[k], m_ac_vx[k]);
        m_ac_y[k] = moved(m_ac_y[k], m_ac_vy[k]);
      end
`endif
    end
  endfunction

  function automatic logic [N*IW-1:0] exp_id();
    logic [N*IW-1:0] r;
    for (int k = 0; k < N; k++) r[k*IW +: IW] = m_ac_id[k];
    return r;
  endfunction
  function automatic logic [N*PW-1:0] exp_x();
    logic [N*PW-1:0] r;
    for (int k = 0; k < N; k++) r[k*PW +: PW] = m_ac_x[k];
    return r;
  endfunction
  function automatic logic [N*PW-1:0] exp_y();
    logic [N*PW-1:0] r;
    for (int k = 0; k < N; k++) r[k*PW +: PW] = m_ac_y[k];
    return r;
  endfunction
  function automatic logic [N*CW-1:0] exp_c();
    logic [N*CW-1:0] r;
    for (int k = 0; k < N; k++) r[k*CW +: CW] = m_ac_c[k];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int idx, input int field, input logic [15:0] d);
    int budget;
    budget   = 20;
    wr_valid = 1'b1; wr_index = idx[5:0]; wr_field = field[2:0]; wr_data = d;
    while (!wr_ready && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready_timeout: wr_ready=%b required 1", wr_ready);
    end else begin
      model_write(idx, field, d);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    m_pending = 1;
  endtask

  logic            obs_tick_t, obs_tick_t1, obs_ready_t1, obs_pend_t1;
  logic [N*IW-1:0] obs_id_t1;

  // Returns in cycle T+2 (T = cycle where the frame-end event is detected).
  task automatic drive_frame_end();
    h_pos = 10'd639; v_pos = 10'd479;
    tick();
    h_pos = 10'd0; v_pos = 10'd0;
    obs_tick_t = frame_tick;
    tick();
    obs_tick_t1 = frame_tick; obs_ready_t1 = wr_ready;
    obs_pend_t1 = commit_pending; obs_id_t1 = sprite_id_out;
    tick();
    model_frame_end();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    model_reset();
    n_checks += 7;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    if (sprite_id_out !== '0) begin n_fail++; $display("FAIL reset_id: nonzero bus"); end
    if (sprite_x_out !== '0) begin n_fail++; $display("FAIL reset_x: nonzero bus"); end
    if (sprite_y_out !== '0) begin n_fail++; $display("FAIL reset_y: nonzero bus"); end
    if (sprite_color_out !== '0) begin n_fail++; $display("FAIL reset_color: nonzero bus"); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_commit_swap();
    logic [N*IW-1:0] pre_id;
    drive_write(63, 0, 16'h0005);
    drive_write(63, 1, 16'h0096);
    drive_write(63, 2, 16'h00A2);
    drive_write(63, 3, 16'hFFFF);
    pulse_commit();
    pre_id = exp_id();
    n_checks += 2;
    if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_rise: got %b want 1", commit_pending); end
    if (sprite_id_out !== pre_id) begin n_fail++; $display("FAIL commit_early_publish: active changed before frame end"); end
    drive_frame_end();
    n_checks += 11;
    if (obs_tick_t !== 1'b0) begin n_fail++; $display("FAIL swap_tick_T: got %b want 0", obs_tick_t); end
    if (obs_tick_t1 !== 1'b1) begin n_fail++; $display("FAIL swap_tick_T1: got %b want 1", obs_tick_t1); end
    if (obs_ready_t1 !== 1'b0) begin n_fail++; $display("FAIL swap_ready_T1: got %b want 0", obs_ready_t1); end
    if (obs_pend_t1 !== 1'b1) begin n_fail++; $display("FAIL swap_pending_T1: got %b want 1", obs_pend_t1); end
    if (obs_id_t1 !== pre_id) begin n_fail++; $display("FAIL swap_id_T1: outputs changed before T+2"); end
    if (sprite_id_out[63*IW +: IW] !== 6'h05) begin n_fail++; $display("FAIL swap_id63: got %h want 05", sprite_id_out[63*IW +: IW]); end
    if (sprite_x_out[63*PW +: PW] !== 10'h096) begin n_fail++; $display("FAIL swap_x63: got %h want 096", sprite_x_out[63*PW +: PW]); end
    if (sprite_y_out[63*PW +: PW] !== 10'h0A2) begin n_fail++; $display("FAIL swap_y63: got %h want 0a2", sprite_y_out[63*PW +: PW]); end
    if (sprite_color_out[63*CW +: CW] !== 16'hFFFF) begin n_fail++; $display("FAIL swap_c63: got %h want ffff", sprite_color_out[63*CW +: CW]); end
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL swap_pending_fall: got %b want 0", commit_pending); end
    if (sprite_color_out !== exp_c()) begin n_fail++; $display("FAIL swap_color_bus: active copy differs from model"); end
  endtask

  task automatic test_no_commit();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 8; i++)
      drive_write($urandom_range(0, N-1), $urandom_range(0, 3), 16'($urandom));
    for (int f = 0; f < 2; f++) begin
      drive_frame_end();
      ticks += int'(obs_tick_t1);
      n_checks++;
      if (obs_ready_t1 !== 1'b1) begin n_fail++; $display("FAIL nocommit_ready: got %b want 1", obs_ready_t1); end
    end
    n_checks += 5;
    if (ticks != 2) begin n_fail++; $display("FAIL nocommit_ticks: got %0d want 2", ticks); end
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL nocommit_pending: got %b want 0", commit_pending); end
    if (sprite_id_out !== exp_id()) begin n_fail++; $display("FAIL nocommit_id: active changed"); end
    if (sprite_x_out !== exp_x()) begin n_fail++; $display("FAIL nocommit_x: active differs"); end
    if (sprite_color_out !== exp_c()) begin n_fail++; $display("FAIL nocommit_color: active changed"); end
  endtask

  task automatic test_write_in_frame_end_cycle();
    int a, b;
    logic [15:0] d1, d2;
    a  = $urandom_range(0, N-1);
    b  = $urandom_range(0, N-1);
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    pulse_commit();
    h_pos = 10'd639; v_pos = 10'd479;
    tick();
    h_pos = 10'd0; v_pos = 10'd0;
    // cycle T: write offered in the frame-end cycle
    wr_valid = 1'b1; wr_index = a[5:0]; wr_field = 3'd1; wr_data = d1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fe_write_ready_T: got %b want 1", wr_ready); end
    tick();
    model_write(a, 1, d1);
    // cycle T+1: swap, write must stall
    wr_index = b[5:0]; wr_field = 3'd2; wr_data = d2;
    n_checks += 2;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fe_write_ready_swap: got %b want 0", wr_ready); end
    if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL fe_tick: got %b want 1", frame_tick); end
    tick();
    model_frame_end();
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fe_write_ready_after: got %b want 1", wr_ready); end
    tick();
    model_write(b, 2, d2);
    wr_valid = 1'b0;
    n_checks += 3;
    if (sprite_x_out[a*PW +: PW] !== d1[PW-1:0]) begin n_fail++; $display("FAIL fe_write_included: got %h want %h", sprite_x_out[a*PW +: PW], d1[PW-1:0]); end
    if (sprite_y_out !== exp_y()) begin n_fail++; $display("FAIL fe_stalled_write_excluded: y bus differs"); end
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL fe_pending: got %b want 0", commit_pending); end
    pulse_commit();
    drive_frame_end();
    n_checks++;
    if (sprite_y_out[b*PW +: PW] !== d2[PW-1:0]) begin n_fail++; $display("FAIL fe_stalled_write_later: got %h want %h", sprite_y_out[b*PW +: PW], d2[PW-1:0]); end
  endtask

  task automatic test_reset_pending();
    drive_write($urandom_range(0, N-1), 3, 16'($urandom));
    pulse_commit();
    n_checks++;
    if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL rstp_pending_before: got %b want 1", commit_pending); end
    rst = 1'b1;
    tick();
    model_reset();
    n_checks += 3;
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL rstp_pending: got %b want 0", commit_pending); end
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_ready: got %b want 0", wr_ready); end
    if (sprite_color_out !== '0) begin n_fail++; $display("FAIL rstp_active_cleared: nonzero bus"); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) drive_write(i, 0, 16'h0021 + 16'(i));
    drive_frame_end();
    n_checks += 3;
    if (obs_ready_t1 !== 1'b1) begin n_fail++; $display("FAIL rstp_no_swap: wr_ready=%b want 1", obs_ready_t1); end
    if (sprite_id_out !== exp_id()) begin n_fail++; $display("FAIL rstp_id: active changed without commit"); end
    if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL rstp_pending_after: got %b want 0", commit_pending); end
  endtask

  task automatic test_random();
    bit do_commit;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'($urandom_range(4, 12)); i++)
        drive_write($urandom_range(0, N-1), $urandom_range(0, 7), 16'($urandom));
      do_commit = ($urandom_range(0, 1) == 1);
      if (do_commit) pulse_commit();
      drive_frame_end();
      n_checks += 6;
      if (obs_tick_t1 !== 1'b1) begin n_fail++; $display("FAIL rand_tick r%0d: got %b want 1", r, obs_tick_t1); end
      if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL rand_pending r%0d: got %b want 0", r, commit_pending); end
      if (sprite_id_out !== exp_id()) begin n_fail++; $display("FAIL rand_id r%0d: bus differs from model", r); end
      if (sprite_x_out !== exp_x()) begin n_fail++; $display("FAIL rand_x r%0d: bus differs from model", r); end
      if (sprite_y_out !== exp_y()) begin n_fail++; $display("FAIL rand_y r%0d: bus differs from model", r); end
      if (sprite_color_out !== exp_c()) begin n_fail++; $display("FAIL rand_color r%0d: bus differs from model", r); end
    end
  endtask

  task automatic test_motion();
    drive_write(10, 1, 16'h03FE);
    drive_write(10, 4, 16'h0003);
    drive_write(20, 1, 16'h0000);
    drive_write(20, 4, 16'h000F);
    pulse_commit();
    drive_frame_end();
    n_checks += 2;
    if (sprite_x_out[10*PW +: PW] !== 10'h3FE) begin n_fail++; $display("FAIL motion_swap_frame x10: got %h want 3fe", sprite_x_out[10*PW +: PW]); end
    if (sprite_x_out[20*PW +: PW] !== 10'h000) begin n_fail++; $display("FAIL motion_swap_frame x20: got %h want 000", sprite_x_out[20*PW +: PW]); end
    drive_frame_end();
    n_checks += 4;
    if (sprite_x_out[10*PW +: PW] !== m_ac_x[10]) begin n_fail++; $display("FAIL motion_wrap_up: got %h want %h", sprite_x_out[10*PW +: PW], m_ac_x[10]); end
    if (sprite_x_out[20*PW +: PW] !== m_ac_x[20]) begin n_fail++; $display("FAIL motion_wrap_down: got %h want %h", sprite_x_out[20*PW +: PW], m_ac_x[20]); end
    if (sprite_x_out !== exp_x()) begin n_fail++; $display("FAIL motion_x_bus: differs from model"); end
    if (sprite_y_out !== exp_y()) begin n_fail++; $display("FAIL motion_y_bus: differs from model"); end
`ifdef SPRITE_MOTION_EN
    n_checks += 2;
    if (sprite_x_out[10*PW +: PW] !== 10'h001) begin n_fail++; $display("FAIL motion_x10_abs: got %h want 001", sprite_x_out[10*PW +: PW]); end
    if (sprite_x_out[20*PW +: PW] !== 10'h3FF) begin n_fail++; $display("FAIL motion_x20_abs: got %h want 3ff", sprite_x_out[20*PW +: PW]); end
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; h_pos = '0; v_pos = '0; wr_valid = 1'b0; wr_index = '0;
    wr_field = '0; wr_data = '0; commit = 1'b0;
    model_reset();
    test_reset();
    test_commit_swap();
    test_no_commit();
    test_write_in_frame_end_cycle();
    test_reset_pending();
    test_random();
    test_motion();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
